// File: rtl/fifo_pkg.sv
// Shared defaults and the output-buffer state type for the FIFO drain block.
package fifo_pkg;

   localparam int DW_DEFAULT      = 8;
   localparam int PKT_LEN_DEFAULT = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_t;

   function automatic logic [1:0] buf_count(input buf_state_t s);
      logic [1:0] n;
      n = 2'd0;
      case (s)
         ONE:     n = 2'd1;
         TWO:     n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer: captures in_data when in_valid, presents the oldest entry.
// state | meaning
// EMPTY | no entry held, out_valid low
// ONE   | head holds the only entry
// TWO   | head is oldest, tail is next
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [1:0]    count
);

   buf_state_t    state;
   logic [DW-1:0] head;
   logic [DW-1:0] tail;
   logic          hs;

   assign hs       = out_valid & out_ready;
   assign out_data = head;
   assign count    = buf_count(state);

   // The drain never offers a capture while TWO is held without a handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         head      <= '0;
         tail      <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_valid) begin
                  head      <= in_data;
                  state     <= ONE;
                  out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (in_valid && hs) begin
                  head <= in_data;
               end else if (in_valid) begin
                  tail  <= in_data;
                  state <= TWO;
               end else if (hs) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            TWO: begin
               if (hs) begin
                  head <= tail;
                  if (in_valid) tail <= in_data;
                  else          state <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fifo_drain.sv
// Drains a registered-output FIFO into a valid/ready stream split into PKT_LEN-beat packets.
module fifo_drain
   import fifo_pkg::*;
#(
   parameter int DW      = DW_DEFAULT,
   parameter int PKT_LEN = PKT_LEN_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fifo_empty,
   input  logic          fifo_wr,
   input  logic [DW-1:0] fifo_dout,
   output logic          fifo_rd,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last
);

   localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

   logic       armed;
   logic       inflight;
   logic [7:0] beat_cnt;
   logic [1:0] count;
   logic [1:0] room_used;
   logic       hs;
   logic       pop;

   assign hs = m_valid & m_ready;

   // Occupancy is taken net of this cycle's handshake so a steady stream never stalls.
   assign room_used = count - {1'b0, hs} + {1'b0, inflight};
   assign fifo_rd   = armed & ~fifo_empty & (room_used < 2'd2);
   assign pop       = fifo_rd & ~fifo_empty & ~fifo_wr;
   assign m_last    = m_valid & (beat_cnt == LAST_BEAT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed    <= 1'b0;
         inflight <= 1'b0;
         beat_cnt <= 8'd0;
      end else begin
         armed    <= 1'b1;
         inflight <= pop;
         if (hs) begin
            if (beat_cnt == LAST_BEAT) beat_cnt <= 8'd0;
            else                       beat_cnt <= beat_cnt + 8'd1;
         end
      end
   end

   fifo_skid_buf #(.DW(DW)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inflight),
      .in_data   (fifo_dout),
      .out_valid (m_valid),
      .out_ready (m_ready),
      .out_data  (m_data),
      .count     (count)
   );

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DW, default 8, width of the data path.
REQ-002 SHALL have parameter PKT_LEN, default 4, number of beats per output packet (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port fifo_empty  input  1  empty flag of the upstream FIFO.
REQ-006 SHALL have port fifo_wr  input  1  write strobe seen by the upstream FIFO (write has priority there).
REQ-007 SHALL have port fifo_dout  input  DW  upstream FIFO read data, registered, valid one cycle after an effective pop.
REQ-008 SHALL have port fifo_rd  output  1  pop request to the upstream FIFO.
REQ-009 SHALL have port m_valid  output  1  output beat valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts the beat.
REQ-011 SHALL have port m_data  output  DW  output beat data.
REQ-012 SHALL have port m_last  output  1  marks the final beat of a PKT_LEN-beat packet.

Function
REQ-013 An effective pop SHALL be defined as fifo_rd & !fifo_empty & !fifo_wr in the same cycle.
REQ-014 A cycle with fifo_rd=1 that is not an effective pop SHALL produce no capture and no state change.
REQ-015 fifo_rd SHALL be combinational: !fifo_empty & (occupancy + inflight < 2).
REQ-016 After an effective pop in cycle N, inflight SHALL be 1 during cycle N+1, and fifo_dout SHALL be captured into the 2-entry output buffer at the end of cycle N+1.
REQ-017 The output buffer SHALL be tracked by a state machine: EMPTY (0 entries), ONE (1 entry), TWO (2 entries).
REQ-018 Transitions: capture only -> occupancy +1; handshake (m_valid & m_ready) only -> -1; both together -> unchanged, with the head replaced by the next entry in order.
REQ-019 Occupancy SHALL never exceed 2, and an entry SHALL never be overwritten or dropped.
REQ-020 m_valid SHALL equal (state != EMPTY), and m_data SHALL be the oldest entry, both driven directly from registers.
REQ-021 m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-022 Best-case latency from effective pop to m_valid SHALL be 2 cycles.
REQ-023 Sustained throughput SHALL be 1 beat/cycle while m_ready=1 and the FIFO is non-empty with fifo_wr low.
REQ-024 An 8-bit beat counter SHALL increment on each output handshake and wrap from PKT_LEN-1 to 0.
REQ-025 m_last SHALL be 1 when m_valid=1 and the beat counter equals PKT_LEN-1.
REQ-026 With PKT_LEN=1, m_last SHALL be 1 on every beat.
REQ-027 m_ready asserted while state=EMPTY SHALL have no effect.

Reset
REQ-028 Assertion of rst=0 SHALL immediately force state=EMPTY, inflight=0, beat counter=0, m_valid=0, m_last=0, m_data=0, and fifo_rd=0.
REQ-029 Reset mid-operation SHALL discard all buffered and in-flight data, with no capture on the first clock edge after release.
REQ-030 fifo_rd SHALL first assert in the cycle after rst deasserts, if fifo_empty=0.

Structure
REQ-031 Package fifo_pkg SHALL hold DW_DEFAULT, PKT_LEN_DEFAULT, and the buffer-state enum (EMPTY, ONE, TWO).
REQ-032 The 2-entry buffer plus its state machine SHALL be the sub-module fifo_skid_buf, with a valid/data input and a valid/ready/data output.
REQ-033 The pop logic, in-flight tracking and packet counter SHALL remain in fifo_drain.

Verification
REQ-034 Single beat: push 0xA5 into the FIFO, m_ready=1 -> fifo_rd pulses once, m_valid high 2 cycles after the pop with m_data=0xA5, m_last=0.
REQ-035 Back-pressure: 6 bytes 0x10..0x15 queued, m_ready=0 -> exactly 2 pops occur, m_data holds 0x10. Then m_ready=1 -> 0x10..0x15 delivered in order with no gaps after refill.
REQ-036 Write collision: fifo_rd=1 and fifo_wr=1 in the same cycle -> no capture. The pop retries the next cycle and the data order is unchanged.
REQ-037 Packets: PKT_LEN=4, 9 beats streamed -> m_last high on beats 4 and 8 only, and the counter equals 1 at the end.
REQ-038 Reset mid-stream: rst=0 asserted with state=TWO and inflight=1 -> m_valid=0 at once. After release with the FIFO empty, no beat appears.
REQ-039 Empty boundary: fifo_empty=1 throughout -> fifo_rd never asserts and m_valid stays 0 regardless of m_ready.
